// File: rtl/serial_min.sv
// rtl/serial_min.sv - bit-serial unsigned minimum selector, MSB first
//
// Loads two W-bit unsigned operands on an accepted start and compares them
// one bit per clock, most significant bit first. After W compare cycles it
// presents the smaller operand with a one-cycle done pulse. Equal operands
// give min_value = 0 with equal = 1, so a real tie can be told apart from a
// minimum that happens to be zero.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   start      compare request, honoured only in IDLE or DONE
//   x, y       unsigned operands, captured on accepted start
//   busy       high during the W compare cycles
//   done       one-cycle pulse, result valid
//   min_value  smaller operand, or 0 on a tie (held until next DONE/reset)
//   equal      captured operands were equal (held until next DONE/reset)

module serial_min #(
    parameter int W  = 4,
    parameter int CW = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] x,
    input  logic [W-1:0] y,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] min_value,
    output logic         equal
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        UNDECIDED = 2'd0,
        X_LESS    = 2'd1,
        Y_LESS    = 2'd2
    } decision_t;

    state_t        state;
    decision_t     decision;
    decision_t     decision_next;
    logic [W-1:0]  sx;
    logic [W-1:0]  sy;
    logic [W-1:0]  hx;
    logic [W-1:0]  hy;
    logic [CW-1:0] cnt;

    // The first differing bit, scanning from the MSB, settles the outcome;
    // later bits are irrelevant so the decision is frozen once set.
    always_comb begin
        decision_next = decision;
        if (decision == UNDECIDED && sx[W-1] != sy[W-1]) begin
            decision_next = sx[W-1] ? Y_LESS : X_LESS;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            decision  <= UNDECIDED;
            sx        <= '0;
            sy        <= '0;
            hx        <= '0;
            hy        <= '0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            min_value <= '0;
            equal     <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        sx       <= x;
                        sy       <= y;
                        hx       <= x;
                        hy       <= y;
                        cnt      <= CW'(W - 1);
                        decision <= UNDECIDED;
                        busy     <= 1'b1;
                        state    <= COMPARE;
                    end else begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                COMPARE: begin
                    decision <= decision_next;
                    sx       <= sx << 1;
                    sy       <= sy << 1;
                    cnt      <= cnt - 1'b1;
                    if (cnt == '0) begin
                        // Last bit examined: publish using the decision that
                        // includes this cycle's bit pair.
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        equal <= (decision_next == UNDECIDED);
                        case (decision_next)
                            X_LESS:  min_value <= hx;
                            Y_LESS:  min_value <= hy;
                            default: min_value <= '0;
                        endcase
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
